// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : mips_defs
//  Brief     : Shared definitions for the MIPS fetch program-counter slice:
//              sequencer state encodings and the default PC width.
//  Revision  : 1.0 - initial release
// ============================================================================
package mips_defs;

  // Default PC / address width in bits.
  localparam int PC_W = 32;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2
  } state_t;

endpackage : mips_defs
`default_nettype wire

// File: rtl/pc_sequencer_incrementer.sv
`default_nettype none
// ============================================================================
//  Module    : incrementer
//  Brief     : N-bit combinational incrementer (out = in + 1), wrapping at
//              2^N. The clock port is part of the shared interface but is
//              not used because the logic is purely combinational.
//  Revision  : 1.0 - initial release
// ============================================================================
module incrementer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic [N-1:0] in,
  output logic [N-1:0] out
);

  localparam logic [N-1:0] C_ONE = {{(N-1){1'b0}}, 1'b1};

  // The clock is kept on the port list for interface compatibility only.
  logic w_unused_clk;
  assign w_unused_clk = clk;

  // Plain +1; the carry out of the top bit is dropped so 2^N-1 wraps to 0.
  assign out = in + C_ONE;

endmodule : incrementer
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module    : pc_sequencer
//  Brief     : Owns the word-addressed MIPS fetch PC. Selects the next PC from
//              branch / jump / stall / +1 with halt and resume control, and
//              drives the IF address, the IF/ID flush and a fetch counter.
//  Revision  : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import mips_defs::*;
#(
  parameter int           N            = PC_W,
  parameter logic [N-1:0] RESET_VECTOR = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  input  logic         jump,
  input  logic [N-1:0] jump_target,
  input  logic         halt_req,
  input  logic         resume,
  output logic [N-1:0] pc,
  output logic         pc_valid,
  output logic         flush,
  output logic         halted,
  output logic [31:0]  fetch_count
);

  state_t       r_state;
  logic [N-1:0] w_pc_inc;
  logic [N-1:0] w_pc_next;
  logic         w_in_run;
  logic         w_redirect;
  logic         w_advance;

  // Sequential +1 path.
  incrementer #(
    .N (N)
  ) u_incrementer (
    .clk (clk),
    .in  (pc),
    .out (w_pc_inc)
  );

  assign w_in_run   = (r_state == S_RUN);
  // A branch is older than a jump, so either one alone is a redirect.
  assign w_redirect = w_in_run && (branch_taken || jump);
  // pc moves on a redirect or on an un-stalled increment.
  assign w_advance  = branch_taken || jump || !stall;
  // Reset overrides any redirect that coincides with it.
  assign flush      = w_redirect && !rst;

  // Next-PC priority mux: branch, then jump, then stall-hold, then +1.
  always_comb begin
    w_pc_next = pc;
    if (branch_taken) begin
      w_pc_next = branch_target;
    end else if (jump) begin
      w_pc_next = jump_target;
    end else if (!stall) begin
      w_pc_next = w_pc_inc;
    end
  end

  // Sequencer FSM with the pc register, fetch counter and registered status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RESET;
      pc          <= RESET_VECTOR;
      fetch_count <= 32'd0;
      pc_valid    <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (r_state)
        S_RESET: begin
          // One settling cycle; requests are ignored here.
          r_state  <= S_RUN;
          pc_valid <= 1'b1;
          halted   <= 1'b0;
        end
        S_RUN: begin
          pc <= w_pc_next;
          if (w_advance) begin
            fetch_count <= fetch_count + 32'd1;
          end
          // Halt is orthogonal to the pc choice made above.
          if (halt_req) begin
            r_state  <= S_HALT;
            pc_valid <= 1'b0;
            halted   <= 1'b1;
          end
        end
        S_HALT: begin
          // pc frozen; only resume is honoured and it beats halt_req.
          if (resume) begin
            r_state  <= S_RUN;
            pc_valid <= 1'b1;
            halted   <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_RESET;
          pc_valid <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module    : tb_pc_sequencer
//  Brief     : Directed, table-driven bench for pc_sequencer with a second
//              8-bit instance for the wrap-around case.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: N=32, RESET_VECTOR=0x100.
  logic        rst = 1'b1, stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic        halt_req = 1'b0, resume = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0;
  logic [31:0] pc, fetch_count;
  logic        pc_valid, flush, halted;

  pc_sequencer #(.N(32), .RESET_VECTOR(32'h100)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .halt_req(halt_req), .resume(resume), .pc(pc), .pc_valid(pc_valid),
    .flush(flush), .halted(halted), .fetch_count(fetch_count)
  );

  // Small instance: N=8, RESET_VECTOR=0.
  logic        s_rst = 1'b1, s_stall = 1'b0, s_bt = 1'b0, s_jump = 1'b0;
  logic        s_hr = 1'b0, s_res = 1'b0;
  logic [7:0]  s_btgt = '0, s_jtgt = '0, s_pc;
  logic [31:0] s_cnt;
  logic        s_valid, s_flush, s_halted;

  pc_sequencer #(.N(8), .RESET_VECTOR(8'h00)) dut8 (
    .clk(clk), .rst(s_rst), .stall(s_stall), .branch_taken(s_bt),
    .branch_target(s_btgt), .jump(s_jump), .jump_target(s_jtgt),
    .halt_req(s_hr), .resume(s_res), .pc(s_pc), .pc_valid(s_valid),
    .flush(s_flush), .halted(s_halted), .fetch_count(s_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, stall, bt;
    logic [31:0] btgt;
    logic        j;
    logic [31:0] jtgt;
    logic        hr, res;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_valid, e_halted;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, input logic s, input logic b,
                              input logic [31:0] bt, input logic j,
                              input logic [31:0] jt, input logic h,
                              input logic rs, input logic ef,
                              input logic [31:0] ep, input logic ev,
                              input logic eh, input logic [31:0] ec);
    vec_t v;
    v.rst = r; v.stall = s; v.bt = b; v.btgt = bt; v.j = j; v.jtgt = jt;
    v.hr = h; v.res = rs; v.e_flush = ef; v.e_pc = ep; v.e_valid = ev;
    v.e_halted = eh; v.e_cnt = ec;
    return v;
  endfunction

  initial begin
    //                rst stl bt btgt   j  jtgt   hr rs | fl pc     vld hlt cnt
    vecs[0]  = mk(1, 0, 0, 0,     0, 0,     0, 0,  0, 32'h100, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0,     0, 0,     0, 0,  0, 32'h100, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0,     0, 0,     0, 0,  0, 32'h101, 1, 0, 1);
    vecs[3]  = mk(0, 0, 0, 0,     0, 0,     0, 0,  0, 32'h102, 1, 0, 2);
    vecs[4]  = mk(0, 0, 1, 32'h40, 1, 32'h80, 0, 0, 1, 32'h40,  1, 0, 3);
    vecs[5]  = mk(0, 0, 0, 0,     1, 32'h20, 0, 0, 1, 32'h20,  1, 0, 4);
    vecs[6]  = mk(0, 1, 0, 0,     0, 0,     0, 0,  0, 32'h20,  1, 0, 4);
    vecs[7]  = mk(0, 1, 0, 0,     0, 0,     0, 0,  0, 32'h20,  1, 0, 4);
    vecs[8]  = mk(0, 1, 0, 0,     0, 0,     0, 0,  0, 32'h20,  1, 0, 4);
    vecs[9]  = mk(0, 0, 0, 0,     0, 0,     0, 0,  0, 32'h21,  1, 0, 5);
    vecs[10] = mk(0, 0, 0, 0,     1, 32'h30, 0, 0, 1, 32'h30,  1, 0, 6);
    vecs[11] = mk(0, 0, 0, 0,     0, 0,     1, 0,  0, 32'h31,  0, 1, 7);
    vecs[12] = mk(0, 0, 0, 0,     1, 32'h99, 0, 0, 0, 32'h31,  0, 1, 7);
    vecs[13] = mk(0, 0, 0, 0,     0, 0,     1, 1,  0, 32'h31,  1, 0, 7);
    vecs[14] = mk(0, 0, 0, 0,     0, 0,     0, 0,  0, 32'h32,  1, 0, 8);
    vecs[15] = mk(0, 1, 0, 0,     0, 0,     1, 0,  0, 32'h32,  0, 1, 8);
    vecs[16] = mk(0, 0, 0, 0,     0, 0,     0, 1,  0, 32'h32,  1, 0, 8);
    vecs[17] = mk(0, 0, 1, 32'h50, 0, 0,    1, 0,  1, 32'h50,  0, 1, 9);
    vecs[18] = mk(0, 0, 0, 0,     0, 0,     0, 1,  0, 32'h50,  1, 0, 9);
    vecs[19] = mk(0, 1, 0, 0,     1, 32'h60, 0, 0, 1, 32'h60,  1, 0, 10);
    vecs[20] = mk(1, 0, 0, 0,     1, 32'h77, 0, 0, 0, 32'h100, 0, 0, 0);
    vecs[21] = mk(0, 0, 0, 0,     0, 0,     0, 0,  0, 32'h100, 1, 0, 0);
    vecs[22] = mk(0, 0, 0, 0,     0, 0,     0, 0,  0, 32'h101, 1, 0, 1);

    // Table pass on the 32-bit instance: flush before the edge, state after.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; stall = vecs[i].stall;
      branch_taken = vecs[i].bt; branch_target = vecs[i].btgt;
      jump = vecs[i].j; jump_target = vecs[i].jtgt;
      halt_req = vecs[i].hr; resume = vecs[i].res;
      #1;
      chk($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].e_flush});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d_pc_valid", i), {31'd0, pc_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].e_halted});
      chk($sformatf("v%0d_fetch_count", i), fetch_count, vecs[i].e_cnt);
    end

    // Wrap-around on the 8-bit instance: jump to 0xFF, then +1 gives 0x00.
    @(negedge clk);
    s_rst = 1'b1;
    @(posedge clk); #1;
    chk("w8_reset_pc", {24'd0, s_pc}, 32'h00);
    chk("w8_reset_valid", {31'd0, s_valid}, 32'd0);
    @(negedge clk);
    s_rst = 1'b0;
    @(posedge clk); #1;
    chk("w8_run_valid", {31'd0, s_valid}, 32'd1);
    @(negedge clk);
    s_jump = 1'b1; s_jtgt = 8'hFF;
    #1;
    chk("w8_jump_flush", {31'd0, s_flush}, 32'd1);
    @(posedge clk); #1;
    chk("w8_jump_pc", {24'd0, s_pc}, 32'hFF);
    @(negedge clk);
    s_jump = 1'b0;
    @(posedge clk); #1;
    chk("w8_wrap_pc", {24'd0, s_pc}, 32'h00);
    chk("w8_wrap_cnt", s_cnt, 32'd2);
    chk("w8_wrap_halted", {31'd0, s_halted}, 32'd0);
    @(posedge clk); #1;
    chk("w8_after_wrap_pc", {24'd0, s_pc}, 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pc_sequencer
`default_nettype wire
